shifter: RTL and testbench
==========================

// Module: shifter
// PURPOSE
//  - Pixel shift register of the CGIA video path, clocked by the dot clock.
//  - Loaded with a 16-bit fetched display word.
//  - Emits pixels MSB-first at 1, 2, 4 or 8 bits per pixel as an 8-bit colour-pen index.
//  - Feeds the palette/colour bus; index_xor_i allows per-cell attribute or inverse effects.
// PARAMETERS
//  - none: register width is fixed at 16 bits and the colour index width at 8 bits.
// PORTS
//  dotclk_i     in   1   dot clock; all state changes on its rising edge
//  rst_i        in   1   reset; asynchronous, active-high
//  dat_i        in   16  word to load into the shift register
//  load_i       in   1   1 = load dat_i on the next rising edge
//  shift1_i     in   1   1bpp mode: shift by 1, output 1-bit pixel
//  shift2_i     in   1   2bpp mode: shift by 2, output 2-bit pixel
//  shift4_i     in   1   4bpp mode: shift by 4, output 4-bit pixel
//  shift8_i     in   1   8bpp mode: shift by 8, output 8-bit pixel
//  index_xor_i  in   8   value XORed into the final colour index
//  color_o      out  8   current colour-pen index (combinational)
// BEHAVIOUR
//  - One clock (dotclk_i); reset is asynchronous and active-high (rst_i).
//  - State: 16-bit register sr. rst_i=1 clears sr to 16'h0000 immediately.
//  - On each rising edge (rst_i=0), priority order:
//    1. load_i=1: sr <= dat_i. The shift flags do not shift on this cycle.
//    2. else shift8_i: sr <= {sr[7:0], 8'h00}
//    3. else shift4_i: sr <= {sr[11:0], 4'h0}
//    4. else shift2_i: sr <= {sr[13:0], 2'b00}
//    5. else shift1_i: sr <= {sr[14:0], 1'b0}
//    6. else: hold.
//  - Zeros always fill from the LSB end. There is no wrap-around.
//  - After all pixels are shifted out, sr = 0 until the next load.
//  - Multiple shift flags set at once: resolve by the priority above (8 > 4 > 2 > 1).
//    The same priority selects the output width.
//  - Pixel extraction is combinational from sr and the flags. No registered output stage.
//  - Latency: a loaded word's first pixel appears right after the load edge.
//  - Pixel by mode, zero-extended to 8 bits:
//    - 8bpp: sr[15:8]
//    - 4bpp: {4'h0, sr[15:12]}
//    - 2bpp: {6'h00, sr[15:14]}
//    - 1bpp: {7'h00, sr[15]}
//    - no flag set: 8'h00
//  - color_o = pixel ^ index_xor_i, across all 8 bits in every mode.
//  - Reset: color_o = 8'h00 ^ index_xor_i, e.g. 8'h00 when index_xor_i = 0.
//  - Reset asserted mid-line: sr is cleared at once. Loading and shifting resume on the
//    first rising edge after rst_i falls.
//  - Mode may change between any two edges. The new width applies to both the next
//    shift amount and the current color_o immediately.
// CONFIGURATION
//  - Macro SHIFTER_INDEX_XOR_EN.
//  - Defined: color_o = pixel ^ index_xor_i, as above.
//  - Undefined: index_xor_i is ignored and color_o = pixel. The port remains present.
//  - The release build and the tests below define SHIFTER_INDEX_XOR_EN.
// TESTING
//  - Load 16'hAAAA with shift1=1, xor=0 -> color_o = 8'h01.
//  - Next edge: load=0, shift1=1 -> sr = 16'h5554, color_o = 8'h00.
//  - Then one edge each: shift2 -> 8'h01; then shift4 -> 8'h05 (sr = 16'h5500).
//  - Load 16'h1234 with shift8 -> color_o = 8'h12; next edge with shift8 -> 8'h34;
//    next edge -> 8'h00.
//  - Load 16'h1234 with shift8, index_xor_i = 8'hF0 -> color_o = 8'hE2.
//  - Assert rst_i between edges with sr nonzero -> sr = 0 without a clock edge,
//    color_o = index_xor_i.
//    Simultaneous load_i and shift8_i -> sr equals dat_i, unshifted.

Source files
------------

// File: rtl/shifter.sv
// -----------------------------------------------------------------------------
// shifter -- pixel shift register of the CGIA video path (dot clock domain).
//
// A 16-bit fetched display word is loaded and shifted out MSB-first at
// 1, 2, 4 or 8 bits per pixel.  The current pixel is extracted
// combinationally from the register and the mode flags, zero-extended to an
// 8-bit colour-pen index and optionally XORed with index_xor_i.
//
// Build option:
//   SHIFTER_INDEX_XOR_EN  defined   : color_o = pixel ^ index_xor_i
//                         undefined : color_o = pixel (index_xor_i ignored,
//                                     port kept so the interface is stable)
//
// Interface rules:
//   - load_i wins over every shift flag; a load cycle never shifts.
//   - Shift flags resolve by priority 8 > 4 > 2 > 1, and the same priority
//     picks the output pixel width, so color_o follows a mode change at once.
//   - Zeros fill from the LSB end; an exhausted word reads as pixel 0.
// -----------------------------------------------------------------------------
module shifter (
    input  logic        dotclk_i,
    input  logic        rst_i,
    input  logic [15:0] dat_i,
    input  logic        load_i,
    input  logic        shift1_i,
    input  logic        shift2_i,
    input  logic        shift4_i,
    input  logic        shift8_i,
    input  logic [7:0]  index_xor_i,
    output logic [7:0]  color_o
);

    logic [15:0] sr;
    logic [7:0]  pixel;

    // Shift register: load has priority, then the widest active shift.
    always_ff @(posedge dotclk_i or posedge rst_i) begin
        if (rst_i) begin
            sr <= 16'h0000;
        end else if (load_i) begin
            sr <= dat_i;
        end else if (shift8_i) begin
            sr <= {sr[7:0], 8'h00};
        end else if (shift4_i) begin
            sr <= {sr[11:0], 4'h0};
        end else if (shift2_i) begin
            sr <= {sr[13:0], 2'b00};
        end else if (shift1_i) begin
            sr <= {sr[14:0], 1'b0};
        end
    end

    // Pixel extraction: width chosen by the same priority as the shift amount.
    always_comb begin
        pixel = 8'h00;
        if (shift8_i) begin
            pixel = sr[15:8];
        end else if (shift4_i) begin
            pixel = {4'h0, sr[15:12]};
        end else if (shift2_i) begin
            pixel = {6'h00, sr[15:14]};
        end else if (shift1_i) begin
            pixel = {7'h00, sr[15]};
        end
    end

`ifdef SHIFTER_INDEX_XOR_EN
    // Attribute / inverse effect applied across the whole colour index.
    assign color_o = pixel ^ index_xor_i;
`else
    // Feature disabled: the XOR input is intentionally left unused.
    logic unused_index_xor;
    assign unused_index_xor = ^index_xor_i;
    assign color_o = pixel;
`endif

endmodule

// File: tb/tb_shifter.sv
// -----------------------------------------------------------------------------
// tb_shifter -- directed bench for the CGIA pixel shifter.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge, or 1 ns after an input change for combinational checks.
// Expected values are hand-computed; the XOR term follows the same build
// option as the design (SHIFTER_INDEX_XOR_EN).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shifter;

    logic        dotclk;
    logic        rst;
    logic [15:0] dat;
    logic        load;
    logic        shift1;
    logic        shift2;
    logic        shift4;
    logic        shift8;
    logic [7:0]  index_xor;
    logic [7:0]  color;

    int n_vec = 0;
    int n_err = 0;

    shifter dut (
        .dotclk_i    (dotclk),
        .rst_i       (rst),
        .dat_i       (dat),
        .load_i      (load),
        .shift1_i    (shift1),
        .shift2_i    (shift2),
        .shift4_i    (shift4),
        .shift8_i    (shift8),
        .index_xor_i (index_xor),
        .color_o     (color)
    );

    // Clock: 10 ns dot clock.
    initial dotclk = 1'b0;
    always #5 dotclk = ~dotclk;

    // Expected colour from a hand-computed pixel and the applied XOR value.
    function automatic logic [7:0] exp_color(input logic [7:0] pix, input logic [7:0] x);
`ifdef SHIFTER_INDEX_XOR_EN
        return pix ^ x;
`else
        return pix;
`endif
    endfunction

    // Drive the control inputs on the falling edge.
    task automatic drive(input logic ld, input logic [15:0] d,
                         input logic s8, input logic s4, input logic s2, input logic s1,
                         input logic [7:0] x);
        @(negedge dotclk);
        load = ld; dat = d;
        shift8 = s8; shift4 = s4; shift2 = s2; shift1 = s1;
        index_xor = x;
    endtask

    // Advance through one rising edge and settle.
    task automatic edge_settle();
        @(posedge dotclk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b1;
        load = 0; dat = 16'h0000; shift8 = 0; shift4 = 0; shift2 = 0; shift1 = 0;
        index_xor = 8'h00;
        repeat (2) @(posedge dotclk);
        #1;
        n_vec++;
        if (color !== 8'h00) begin
            n_err++; $display("FAIL reset_color: got %02h expected %02h", color, 8'h00);
        end
        index_xor = 8'h5A; shift8 = 1;
        #1;
        e = exp_color(8'h00, 8'h5A);
        n_vec++;
        if (color !== e) begin
            n_err++; $display("FAIL reset_xor: got %02h expected %02h", color, e);
        end
        @(negedge dotclk);
        rst = 1'b0; index_xor = 8'h00; shift8 = 0;
    endtask

    task automatic test_shift_modes();
        // Load AAAA in 1bpp: first pixel is sr[15] = 1.
        drive(1, 16'hAAAA, 0, 0, 0, 1, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h01) begin
            n_err++; $display("FAIL load_1bpp: got %02h expected %02h", color, 8'h01);
        end
        // Shift by 1: sr = 5554, pixel 0.
        drive(0, 16'h0000, 0, 0, 0, 1, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h00) begin
            n_err++; $display("FAIL shift1: got %02h expected %02h", color, 8'h00);
        end
        // Shift by 2: sr = 5550, 2bpp pixel 01.
        drive(0, 16'h0000, 0, 0, 1, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h01) begin
            n_err++; $display("FAIL shift2: got %02h expected %02h", color, 8'h01);
        end
        // Shift by 4: sr = 5500, 4bpp pixel 5.
        drive(0, 16'h0000, 0, 1, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h05) begin
            n_err++; $display("FAIL shift4: got %02h expected %02h", color, 8'h05);
        end
        // Switch to 8bpp without an edge: sr[15:8] = 55 immediately.
        shift4 = 0; shift8 = 1;
        #1;
        n_vec++;
        if (color !== 8'h55) begin
            n_err++; $display("FAIL mode_switch_8: got %02h expected %02h", color, 8'h55);
        end
    endtask

    task automatic test_shift8_drain();
        drive(1, 16'h1234, 1, 0, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h12) begin
            n_err++; $display("FAIL load_8bpp: got %02h expected %02h", color, 8'h12);
        end
        drive(0, 16'h0000, 1, 0, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h34) begin
            n_err++; $display("FAIL shift8_second: got %02h expected %02h", color, 8'h34);
        end
        edge_settle();
        n_vec++;
        if (color !== 8'h00) begin
            n_err++; $display("FAIL shift8_drained: got %02h expected %02h", color, 8'h00);
        end
        // No wrap-around: further shifts keep zeros.
        edge_settle();
        n_vec++;
        if (color !== 8'h00) begin
            n_err++; $display("FAIL shift8_nowrap: got %02h expected %02h", color, 8'h00);
        end
    endtask

    task automatic test_xor();
        logic [7:0] e;
        drive(1, 16'h1234, 1, 0, 0, 0, 8'hF0);
        edge_settle();
        e = exp_color(8'h12, 8'hF0);
        n_vec++;
        if (color !== e) begin
            n_err++; $display("FAIL xor_8bpp: got %02h expected %02h", color, e);
        end
        // Same sr in 4bpp: pixel 01, XOR covers all 8 bits.
        shift8 = 0; shift4 = 1;
        #1;
        e = exp_color(8'h01, 8'hF0);
        n_vec++;
        if (color !== e) begin
            n_err++; $display("FAIL xor_4bpp: got %02h expected %02h", color, e);
        end
        // No mode flag: pixel is 0, color is just the XOR value.
        shift4 = 0; index_xor = 8'h3C;
        #1;
        e = exp_color(8'h00, 8'h3C);
        n_vec++;
        if (color !== e) begin
            n_err++; $display("FAIL xor_noflag: got %02h expected %02h", color, e);
        end
    endtask

    task automatic test_priority();
        // Load with shift8 set: sr = ABCD unshifted.
        drive(1, 16'hABCD, 1, 0, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'hAB) begin
            n_err++; $display("FAIL load_over_shift8: got %02h expected %02h", color, 8'hAB);
        end
        // shift8 + shift1: shift by 8, sr = CD00.
        drive(0, 16'h0000, 1, 0, 0, 1, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'hCD) begin
            n_err++; $display("FAIL prio_8_over_1: got %02h expected %02h", color, 8'hCD);
        end
        // Load C3A5 with shift4 + shift2: 4bpp pixel C.
        drive(1, 16'hC3A5, 0, 1, 1, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h0C) begin
            n_err++; $display("FAIL prio_4_over_2_load: got %02h expected %02h", color, 8'h0C);
        end
        // Edge with shift4 + shift2: shift by 4, sr = 3A50, pixel 3.
        drive(0, 16'h0000, 0, 1, 1, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h03) begin
            n_err++; $display("FAIL prio_4_over_2_shift: got %02h expected %02h", color, 8'h03);
        end
        // shift2 + shift1: shift by 2, sr = E940, 2bpp pixel 3.
        drive(0, 16'h0000, 0, 0, 1, 1, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h03) begin
            n_err++; $display("FAIL prio_2_over_1: got %02h expected %02h", color, 8'h03);
        end
    endtask

    task automatic test_hold();
        // No flags: hold sr = E940 for two edges, pixel reads 0.
        drive(0, 16'h0000, 0, 0, 0, 0, 8'h00);
        edge_settle();
        edge_settle();
        n_vec++;
        if (color !== 8'h00) begin
            n_err++; $display("FAIL hold_noflag: got %02h expected %02h", color, 8'h00);
        end
        shift8 = 1;
        #1;
        n_vec++;
        if (color !== 8'hE9) begin
            n_err++; $display("FAIL hold_kept: got %02h expected %02h", color, 8'hE9);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        drive(1, 16'hFFFF, 1, 0, 0, 0, 8'h33);
        edge_settle();
        load = 0;
        // Mid-cycle reset: sr clears without a clock edge.
        #2 rst = 1'b1;
        #1;
        e = exp_color(8'h00, 8'h33);
        n_vec++;
        if (color !== e) begin
            n_err++; $display("FAIL async_reset: got %02h expected %02h", color, e);
        end
        // Load held during reset must not take effect.
        load = 1; dat = 16'h8765;
        edge_settle();
        n_vec++;
        if (color !== e) begin
            n_err++; $display("FAIL reset_blocks_load: got %02h expected %02h", color, e);
        end
        // Release and load again on the first edge afterwards.
        drive(1, 16'h8765, 1, 0, 0, 0, 8'h00);
        rst = 1'b0;
        edge_settle();
        n_vec++;
        if (color !== 8'h87) begin
            n_err++; $display("FAIL resume_after_reset: got %02h expected %02h", color, 8'h87);
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive loads replace the word each edge.
        drive(1, 16'hF00F, 0, 1, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h0F) begin
            n_err++; $display("FAIL b2b_first: got %02h expected %02h", color, 8'h0F);
        end
        drive(1, 16'h6900, 0, 1, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h06) begin
            n_err++; $display("FAIL b2b_second: got %02h expected %02h", color, 8'h06);
        end
        drive(0, 16'h0000, 0, 1, 0, 0, 8'h00);
        edge_settle();
        n_vec++;
        if (color !== 8'h09) begin
            n_err++; $display("FAIL b2b_shift: got %02h expected %02h", color, 8'h09);
        end
    endtask

    initial begin
        test_reset();
        test_shift_modes();
        test_shift8_drain();
        test_xor();
        test_priority();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
